// File: rtl/register_file_pkg.sv
// Shared defaults and payload types for the RV32I integer register file.
package register_file_pkg;

    localparam int unsigned DWIDTH_DEF = 32;
    localparam int unsigned WIDTH_DEF  = 5;
    localparam int unsigned RWIDTH_DEF = 32;

    typedef logic [WIDTH_DEF-1:0]  reg_addr_t;
    typedef logic [DWIDTH_DEF-1:0] reg_data_t;

endpackage

// File: rtl/register_file_rport.sv
// One combinational read port: address decode, x0/out-of-range masking and
// optional write-through forwarding (enabled by defining REGFILE_BYPASS_EN).
module register_file_rport
    import register_file_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned RWIDTH = RWIDTH_DEF
) (
    input  logic [WIDTH-1:0]  ra,
    input  logic [DWIDTH-1:0] regs [RWIDTH],
    input  logic              fwd_en,
    input  logic [WIDTH-1:0]  wa,
    input  logic [DWIDTH-1:0] wd,
    output logic [DWIDTH-1:0] rd_c
);

    logic [DWIDTH-1:0] stored_c;

    // Entry 0 is never selected, so x0 and unimplemented addresses read zero.
    always_comb begin
        stored_c = '0;
        for (int i = 1; i < int'(RWIDTH); i++) begin
            if (ra == WIDTH'(i)) begin
                stored_c = regs[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // fwd_en already excludes x0, out-of-range addresses and reset.
    always_comb begin
        rd_c = stored_c;
        if (fwd_en && (ra == wa)) begin
            rd_c = wd;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_en, wa, wd};
    assign rd_c       = stored_c;
`endif

endmodule

// File: rtl/register_file.sv
// RV32I integer register file: two combinational read ports, one synchronous
// write port, x0 hardwired to zero. Define REGFILE_BYPASS_EN for write-through.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEF,
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned RWIDTH = RWIDTH_DEF
) (
    input  logic              Clk,
    input  logic              N_Rst,
    input  logic              WE3,
    input  logic [WIDTH-1:0]  WA3,
    input  logic [DWIDTH-1:0] WD3,
    input  logic [WIDTH-1:0]  RA1,
    input  logic [WIDTH-1:0]  RA2,
    output logic [DWIDTH-1:0] RD1,
    output logic [DWIDTH-1:0] RD2
);

    localparam logic [WIDTH:0] RLIM = (WIDTH+1)'(RWIDTH);

    logic [DWIDTH-1:0] regs [RWIDTH];
    logic              wr_ok_c;
    logic              fwd_en_c;

    assign wr_ok_c  = WE3 && (WA3 != '0) && ({1'b0, WA3} < RLIM);
    assign fwd_en_c = wr_ok_c && N_Rst;

    // Storage; reset wins over any concurrent write.
    always_ff @(posedge Clk or negedge N_Rst) begin
        if (!N_Rst) begin
            for (int i = 0; i < int'(RWIDTH); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok_c) begin
            for (int i = 1; i < int'(RWIDTH); i++) begin
                if (WA3 == WIDTH'(i)) begin
                    regs[i] <= WD3;
                end
            end
        end
    end

    register_file_rport #(
        .DWIDTH (DWIDTH),
        .WIDTH  (WIDTH),
        .RWIDTH (RWIDTH)
    ) u_rport1 (
        .ra     (RA1),
        .regs   (regs),
        .fwd_en (fwd_en_c),
        .wa     (WA3),
        .wd     (WD3),
        .rd_c   (RD1)
    );

    register_file_rport #(
        .DWIDTH (DWIDTH),
        .WIDTH  (WIDTH),
        .RWIDTH (RWIDTH)
    ) u_rport2 (
        .ra     (RA2),
        .regs   (regs),
        .fwd_en (fwd_en_c),
        .wa     (WA3),
        .wd     (WD3),
        .rd_c   (RD2)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file (RWIDTH=16) against an array model.
module tb_register_file;
    import register_file_pkg::*;

    localparam int unsigned NREG = 16;

    logic      Clk = 1'b0;
    logic      N_Rst;
    logic      WE3;
    reg_addr_t WA3, RA1, RA2;
    reg_data_t WD3, RD1, RD2;

    reg_data_t mdl [32];
    int        checks   = 0;
    int        failures = 0;

    register_file #(
        .DWIDTH (32),
        .WIDTH  (5),
        .RWIDTH (NREG)
    ) dut (
        .Clk   (Clk),
        .N_Rst (N_Rst),
        .WE3   (WE3),
        .WA3   (WA3),
        .WD3   (WD3),
        .RA1   (RA1),
        .RA2   (RA2),
        .RD1   (RD1),
        .RD2   (RD2)
    );

    always #5 Clk = ~Clk;

    function automatic reg_data_t exp_rd(input reg_addr_t a);
        if (a == 0 || int'(a) >= int'(NREG)) return '0;
        return mdl[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mdl[i] = '0;
    endtask

    task automatic chk(input string tag, input reg_data_t obs, input reg_data_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a write for one rising edge; model applies it only out of reset.
    task automatic do_write(input logic we, input reg_addr_t wa, input reg_data_t wd);
        @(negedge Clk);
        WE3 = we; WA3 = wa; WD3 = wd;
        @(posedge Clk);
        if (N_Rst && we && wa != 0 && int'(wa) < int'(NREG)) mdl[wa] = wd;
        #1;
        WE3 = 1'b0;
    endtask

    task automatic read_check(input string tag, input reg_addr_t a1, input reg_addr_t a2);
        RA1 = a1; RA2 = a2;
        #1;
        chk({tag, "_rd1"}, RD1, exp_rd(a1));
        chk({tag, "_rd2"}, RD2, exp_rd(a2));
    endtask

    initial begin
        reg_addr_t a;
        reg_data_t d, old;
        N_Rst = 1'b0; WE3 = 1'b0; WA3 = '0; WD3 = '0; RA1 = 5'd1; RA2 = 5'd2;
        clear_model();
        #2;
        chk("in_reset_rd1", RD1, 32'h0);
        chk("in_reset_rd2", RD2, 32'h0);
        #8;
        N_Rst = 1'b1;
        read_check("after_reset", 5'd1, 5'd2);

        do_write(1'b1, 5'd1, 32'hA5A5A5A5);
        read_check("wr_reg1", 5'd1, 5'd1);
        do_write(1'b1, 5'd2, 32'h5A5A5A5A);
        read_check("wr_reg2", 5'd1, 5'd2);
        chk("wr_reg2_const", RD2, 32'h5A5A5A5A);

        // Asynchronous reset mid-cycle, away from any clock edge.
        @(negedge Clk);
        #2;
        N_Rst = 1'b0;
        clear_model();
        #1;
        chk("async_rst_rd1", RD1, 32'h0);
        chk("async_rst_rd2", RD2, 32'h0);
        // Write presented during reset is lost and never forwarded.
        WE3 = 1'b1; WA3 = 5'd1; WD3 = 32'hCAFEF00D; RA1 = 5'd1;
        #1;
        chk("rst_no_fwd", RD1, 32'h0);
        do_write(1'b1, 5'd1, 32'hCAFEF00D);
        @(negedge Clk);
        N_Rst = 1'b1;
        read_check("write_in_reset_lost", 5'd1, 5'd2);

        do_write(1'b1, 5'd0, 32'hFFFFFFFF);
        read_check("x0_hardwired", 5'd0, 5'd0);
        do_write(1'b1, 5'd20, 32'h12345678);
        read_check("out_of_range", 5'd20, 5'd16);
        do_write(1'b1, 5'd15, 32'h0F0F0F0F);
        read_check("top_reg", 5'd15, 5'd14);

        // Same-cycle write and read of reg 3.
        do_write(1'b1, 5'd3, 32'h11111111);
        @(negedge Clk);
        old = mdl[3];
        WE3 = 1'b1; WA3 = 5'd3; WD3 = 32'hDEADBEEF; RA1 = 5'd3; RA2 = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("same_cycle_before", RD1, 32'hDEADBEEF);
`else
        chk("same_cycle_before", RD1, old);
`endif
        @(posedge Clk);
        mdl[3] = 32'hDEADBEEF;
        #1;
        WE3 = 1'b0;
        #1;
        chk("same_cycle_after", RD1, 32'hDEADBEEF);
        chk("same_cycle_after_rd2", RD2, 32'hDEADBEEF);

        // Randomized writes and reads against the array model.
        for (int i = 0; i < 300; i++) begin
            a = reg_addr_t'($urandom_range(31, 0));
            d = reg_data_t'($urandom);
            do_write(1'($urandom_range(1, 0)), a, d);
            if ($urandom_range(3, 0) == 0)
                read_check("rand_same", a, a);
            else
                read_check("rand", reg_addr_t'($urandom_range(31, 0)),
                           reg_addr_t'($urandom_range(31, 0)));
        end

        // Full sweep of every address, no X anywhere.
        for (int i = 0; i < 32; i++) begin
            read_check("sweep", reg_addr_t'(i), reg_addr_t'(31 - i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
